fifo_to_axis: RTL

FIFO_TO_AXIS -- requirements
Module: fifo_to_axis

---
 rtl/fifo_to_axis.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_to_axis.sv
// Drains a fixed number of words from a first-word-fall-through FIFO onto an
// AXI-Stream master port, marking the final beat with tlast and pulsing o_done.
module fifo_to_axis #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] pop_cnt;
  logic                 start_ok;
  logic                 handshake;
  logic                 last_pop;

  assign start_ok  = (state == IDLE) && i_start;
  assign handshake = m_axis_tvalid && m_axis_tready;
  // pop_cnt < len_q whenever a pop happens, so the increment never wraps.
  assign last_pop  = o_fifo_rd && ((pop_cnt + ONE) == len_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: defaults at the top of combinational processes prevent latches on
  // paths that do not assign every output.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok && (i_len != '0)) state_next = RUN;
      RUN:     if (last_pop) state_next = LAST;
      LAST:    if (handshake && m_axis_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != IDLE);
    o_fifo_rd = (state == RUN) && !i_fifo_empty && (!m_axis_tvalid || m_axis_tready);
  end

  // Output skid register: a pop refills it, an accepted beat with no refill empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q         <= '0;
      pop_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= (start_ok && (i_len == '0)) ||
                ((state == LAST) && handshake && m_axis_tlast);
      if (start_ok) begin
        len_q   <= i_len;
        pop_cnt <= '0;
      end
      if (o_fifo_rd) begin
        m_axis_tdata  <= i_fifo_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= last_pop;
        pop_cnt       <= pop_cnt + ONE;
      end else if (handshake) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule
